// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - parallel layer output vector to one-word-per-cycle serial stream
// Optional SER_LAST_EN adds o_last, marking the final word of each vector.
module layer_serializer #(
    parameter int numOutput = 10,
    parameter int dataWidth = 16
) (
    input  logic                           i_clk,
    input  logic                           rst,
    input  logic [numOutput*dataWidth-1:0] i_data,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [dataWidth-1:0]           o_data,
    output logic                           o_data_valid,
    output logic                           o_busy,
`ifdef SER_LAST_EN
    output logic                           o_last,
`endif
    output logic                           o_overflow
);

    localparam int CW = $clog2(numOutput);
    localparam logic [CW-1:0] LAST_IDX = CW'(numOutput - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [dataWidth-1:0] buf_q [numOutput];
    logic                 at_last;
    logic                 accept;
    logic                 drop;

    // cnt_q is the index of the word currently shown on o_data, so the
    // ready window coincides with the last word and the next vector follows gaplessly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        at_last = (state_q == SEND) && (cnt_q == LAST_IDX);
        o_ready = (state_q == IDLE) || at_last;
        accept  = i_valid && o_ready;
        drop    = i_valid && !o_ready;
        if (accept) begin
            state_d = SEND;
            cnt_d   = '0;
        end else if (at_last) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == SEND) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_overflow   <= 1'b0;
`ifdef SER_LAST_EN
            o_last       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_data_valid <= (state_d == SEND);
            o_busy       <= (state_d == SEND);
`ifdef SER_LAST_EN
            o_last       <= (state_d == SEND) && (cnt_d == LAST_IDX);
`endif
            // Word 0 bypasses the buffer so it shows the cycle after the accept.
            if (accept) begin
                for (int k = 0; k < numOutput; k++) begin
                    buf_q[k] <= i_data[k*dataWidth +: dataWidth];
                end
                o_data <= i_data[dataWidth-1:0];
            end else if (state_d == SEND) begin
                o_data <= buf_q[cnt_d];
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - vector table, corner sequences and randomized model check for layer_serializer
module tb_layer_serializer;

    localparam int N = 10;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] i_data;
    logic           i_valid;
    logic           o_ready;
    logic [W-1:0]   o_data;
    logic           o_data_valid;
    logic           o_busy;
    logic           o_overflow;
`ifdef SER_LAST_EN
    logic           o_last;
`endif

    layer_serializer #(.numOutput(N), .dataWidth(W)) dut (
        .i_clk       (clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_busy      (o_busy),
`ifdef SER_LAST_EN
        .o_last      (o_last),
`endif
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic         rst;
        logic         vin;
        logic [W-1:0] base;
        logic [W-1:0] inc;
        logic         er;
        logic         ev;
        logic [W-1:0] ed;
        logic         eo;
        logic         el;
    } row_t;

    row_t tab[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] base, input logic [W-1:0] inc);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = base + inc * W'(k);
        return v;
    endfunction

    task automatic add(input logic r, input logic v, input logic [W-1:0] b, input logic [W-1:0] inc,
                       input logic er, input logic ev, input logic [W-1:0] ed, input logic eo, input logic el);
        row_t x;
        x.rst = r; x.vin = v; x.base = b; x.inc = inc;
        x.er = er; x.ev = ev; x.ed = ed; x.eo = eo; x.el = el;
        tab.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [W-1:0] ed, input logic eo, input logic el);
        chk({nm, "_valid"}, o_data_valid, ev);
        chk({nm, "_busy"}, o_busy, ev);
        chk({nm, "_data"}, o_data, ed);
        chk({nm, "_ovf"}, o_overflow, eo);
`ifdef SER_LAST_EN
        chk({nm, "_last"}, o_last, el);
`else
        if (el === 1'bx) chk({nm, "_last_x"}, el, 1'b0);
`endif
    endtask

    // Accept a vector and check it streams out word by word, then goes idle.
    task automatic stream_check(input string nm, input logic [N*W-1:0] d, input logic eo);
        chk({nm, "_ready0"}, o_ready, 1'b1);
        i_data = d;
        i_valid = 1'b1;
        tick();
        for (int k = 0; k < N; k++) begin
            chk_out(nm, 1'b1, d[k*W +: W], eo, k == N - 1);
            if (k < N - 1) tick();
        end
        tick();
        chk_out({nm, "_end"}, 1'b0, d[(N-1)*W +: W], eo, 1'b0);
    endtask

    logic [W-1:0]   q[$];
    bit             lq[$];
    bit             m_ovf;
    logic [W-1:0]   m_ld;
    logic [N*W-1:0] neg_v;
    logic [W-1:0]   neg_w [N];

    initial begin
        rst = 1'b1;
        i_valid = 1'b0;
        i_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_out("reset", 1'b0, '0, 1'b0, 1'b0);
        chk("reset_ready", o_ready, 1'b1);

        // Basic stream
        add(0, 1, 16'h0100, 1, 1, 1, 16'h0100, 0, 0);
        for (int j = 1; j < N; j++) add(0, 0, 0, 0, 0, 1, 16'(16'h0100 + j), 0, j == N - 1);
        add(0, 0, 0, 0, 1, 0, 16'h0109, 0, 0);
        add(0, 0, 0, 0, 1, 0, 16'h0109, 0, 0);
        // Back-to-back: second accept while word 9 is shown
        add(0, 1, 16'h0100, 1, 1, 1, 16'h0100, 0, 0);
        for (int j = 1; j < N; j++) add(0, 0, 0, 0, 0, 1, 16'(16'h0100 + j), 0, j == N - 1);
        add(0, 1, 16'h0200, 1, 1, 1, 16'h0200, 0, 0);
        for (int j = 1; j < N; j++) add(0, 0, 0, 0, 0, 1, 16'(16'h0200 + j), 0, j == N - 1);
        add(0, 0, 0, 0, 1, 0, 16'h0209, 0, 0);
        // Overflow: DEAD vector offered while word 3 is shown
        add(0, 1, 16'h0100, 1, 1, 1, 16'h0100, 0, 0);
        for (int j = 1; j < 4; j++) add(0, 0, 0, 0, 0, 1, 16'(16'h0100 + j), 0, 0);
        add(0, 1, 16'hDEAD, 0, 0, 1, 16'h0104, 1, 0);
        for (int j = 5; j < N; j++) add(0, 0, 0, 0, 0, 1, 16'(16'h0100 + j), 1, j == N - 1);
        add(0, 0, 0, 0, 1, 0, 16'h0109, 1, 0);
        add(0, 0, 0, 0, 1, 0, 16'h0109, 1, 0);

        foreach (tab[i]) begin
            rst = tab[i].rst;
            i_valid = tab[i].vin;
            i_data = pack(tab[i].base, tab[i].inc);
            #1;
            chk($sformatf("tab%0d_ready", i), o_ready, tab[i].er);
            tick();
            chk_out($sformatf("tab%0d", i), tab[i].ev, tab[i].ed, tab[i].eo, tab[i].el);
        end

        // Mid-stream reset during word 5 (overflow is still set from above)
        i_data = pack(16'h0300, 1);
        i_valid = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) tick();
        chk("mrst_word5", o_data, 16'h0305);
        rst = 1'b1;
        tick();
        chk_out("mrst", 1'b0, '0, 1'b0, 1'b0);
        chk("mrst_ready", o_ready, 1'b1);
        stream_check("after_rst", pack(16'h0400, 1), 1'b0);

        // rst and i_valid together while busy: reset wins, no overflow, nothing accepted
        i_data = pack(16'h0500, 1);
        i_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("rv_word2", o_data, 16'h0502);
        rst = 1'b1;
        i_valid = 1'b1;
        i_data = pack(16'h0600, 1);
        tick();
        chk_out("rv_busy", 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        i_valid = 1'b1;
        tick();
        tick();
        chk_out("rv_idle", 1'b0, '0, 1'b0, 1'b0);

        // Negative and full-scale words pass bit-exact
        neg_w = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8001,
                  16'hFFFE, 16'h0001, 16'h7FFE, 16'hAAAA, 16'h5555};
        for (int k = 0; k < N; k++) neg_v[k*W +: W] = neg_w[k];
        stream_check("neg", neg_v, 1'b0);

        // Randomized run against a queue model of the emitted stream
        rst = 1'b1;
        tick();
        q.delete();
        lq.delete();
        m_ovf = 0;
        m_ld = '0;
        for (int c = 0; c < 3000; c++) begin
            bit r;
            bit v;
            bit exp_ready;
            logic [N*W-1:0] d;
            r = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 5) == 0) || (q.size() == 1 && $urandom_range(0, 1) == 1);
            for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
            rst = r;
            i_valid = v;
            i_data = d;
            #1;
            exp_ready = (q.size() <= 1);
            chk("rnd_ready", o_ready, exp_ready);
            tick();
            if (r) begin
                q.delete();
                lq.delete();
                m_ovf = 0;
                m_ld = '0;
            end else begin
                if (q.size() > 0) begin
                    void'(q.pop_front());
                    void'(lq.pop_front());
                end
                if (v) begin
                    if (exp_ready) begin
                        for (int k = 0; k < N; k++) begin
                            q.push_back(d[k*W +: W]);
                            lq.push_back(k == N - 1);
                        end
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (q.size() > 0) m_ld = q[0];
            chk_out("rnd", q.size() > 0, m_ld, m_ovf, q.size() > 0 ? lq[0] : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
